// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared memory port and a single ALU, with configurable memory wait states.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_LAT = 0,
  parameter bit          JAL_EN  = 1'b1
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] Mem2Reg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [2:0] ALUControl,
  output logic       PCWrite,
  output logic       BranchEq,
  output logic       BranchNeq,
  output logic [1:0] PCSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StMadr = 4'd2,
    StMrd  = 4'd3,
    StMwb  = 4'd4,
    StMwr  = 4'd5,
    StExr  = 4'd6,
    StWbr  = 4'd7,
    StBr   = 4'd8,
    StJmp  = 4'd9,
    StExi  = 4'd10,
    StWbi  = 4'd11,
    StJal  = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluLui = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [3:0] LatLast = 4'(MEM_LAT);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       mem_done;

  logic [2:0] r_ctrl;
  logic       r_ok;
  logic [2:0] i_ctrl;
  logic       i_sext;
  state_e     id_next;
  logic       id_illegal;

  // The datapath gates BranchEq/BranchNeq with zero itself.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_done = (cnt_q == LatLast);
  assign state    = state_q;

  // Instruction decode: R-type func, I-type ALU op, and the ID dispatch target.
  always_comb begin
    r_ctrl = AluAdd;
    r_ok   = 1'b1;
    case (func)
      FnAdd:   r_ctrl = AluAdd;
      FnSub:   r_ctrl = AluSub;
      FnAnd:   r_ctrl = AluAnd;
      FnOr:    r_ctrl = AluOr;
      FnNor:   r_ctrl = AluNor;
      FnSlt:   r_ctrl = AluSlt;
      default: r_ok   = 1'b0;
    endcase

    i_ctrl = AluAdd;
    i_sext = 1'b1;
    case (opcode)
      OpSlti: i_ctrl = AluSlt;
      OpAndi: begin
        i_ctrl = AluAnd;
        i_sext = 1'b0;
      end
      OpOri: begin
        i_ctrl = AluOr;
        i_sext = 1'b0;
      end
      OpLui: begin
        i_ctrl = AluLui;
        i_sext = 1'b0;
      end
      default: ;
    endcase

    id_next    = StIf;
    id_illegal = 1'b0;
    case (opcode)
      OpRtype: begin
        if (r_ok) id_next = StExr;
        else      id_illegal = 1'b1;
      end
      OpLw, OpSw:   id_next = StMadr;
      OpBeq, OpBne: id_next = StBr;
      OpJ:          id_next = StJmp;
      OpJal: begin
        if (JAL_EN) id_next = StJal;
        else        id_illegal = 1'b1;
      end
      OpAddi, OpSlti, OpAndi, OpOri, OpLui: id_next = StExi;
      default: id_illegal = 1'b1;
    endcase
  end

  // Wait counter only runs in IF/MRD/MWR and is cleared on every exit from them.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q <= StIf;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        StIf: begin
          if (mem_done) begin
            cnt_q   <= 4'd0;
            state_q <= StId;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StId:   state_q <= id_next;
        StMadr: state_q <= (opcode == OpSw) ? StMwr : StMrd;
        StMrd: begin
          if (mem_done) begin
            cnt_q   <= 4'd0;
            state_q <= StMwb;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StMwr: begin
          if (mem_done) begin
            cnt_q   <= 4'd0;
            state_q <= StIf;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StExr:   state_q <= StWbr;
        StExi:   state_q <= StWbi;
        default: state_q <= StIf;
      endcase
    end
  end

  // Moore outputs; everything held at zero while reset is high.
  always_comb begin
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 2'd0;
    Mem2Reg    = 2'd0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    ExtOp      = 1'b0;
    ALUControl = 3'b000;
    PCWrite    = 1'b0;
    BranchEq   = 1'b0;
    BranchNeq  = 1'b0;
    PCSrc      = 2'd0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        StIf: begin
          MemRead    = 1'b1;
          ALUSrcB    = 2'd1;
          ALUControl = AluAdd;
          IRWrite    = mem_done;
          PCWrite    = mem_done;
        end
        StId: begin
          ALUSrcB    = 2'd3;
          ExtOp      = 1'b1;
          ALUControl = AluAdd;
          illegal    = id_illegal;
        end
        StMadr: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'd2;
          ExtOp      = 1'b1;
          ALUControl = AluAdd;
        end
        StMrd: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        StMwr: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        StMwb: begin
          Mem2Reg  = 2'd1;
          RegWrite = 1'b1;
        end
        StExr: begin
          ALUSrcA    = 1'b1;
          ALUControl = r_ctrl;
        end
        StWbr: begin
          RegDst   = 2'd1;
          RegWrite = 1'b1;
        end
        StExi: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'd2;
          ExtOp      = i_sext;
          ALUControl = i_ctrl;
        end
        StWbi: RegWrite = 1'b1;
        StBr: begin
          ALUSrcA    = 1'b1;
          ALUControl = AluSub;
          PCSrc      = 2'd1;
          BranchEq   = (opcode == OpBeq);
          BranchNeq  = (opcode == OpBne);
        end
        StJmp: begin
          PCWrite = 1'b1;
          PCSrc   = 2'd2;
        end
        StJal: begin
          PCWrite  = 1'b1;
          PCSrc    = 2'd2;
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          Mem2Reg  = 2'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: four instances cover MEM_LAT 0/2/3 and JAL_EN=0.
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [4];
  logic [5:0] op   [4];
  logic [5:0] fn   [4];
  logic       zero;

  logic       iord [4];
  logic       mrd  [4];
  logic       mwr  [4];
  logic       irw  [4];
  logic       rgw  [4];
  logic [1:0] rdst [4];
  logic [1:0] m2r  [4];
  logic       srca [4];
  logic [1:0] srcb [4];
  logic       ext  [4];
  logic [2:0] aluc [4];
  logic       pcw  [4];
  logic       beq  [4];
  logic       bne  [4];
  logic [1:0] pcs  [4];
  logic       ill  [4];
  logic [3:0] st   [4];

  int errors = 0;
  int checks = 0;

  // Instance 0: L=0, 1: L=2, 2: L=3, 3: L=0 with jal disabled.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    multi_cycle_ctrl #(
      .MEM_LAT(g == 1 ? 2 : (g == 2 ? 3 : 0)),
      .JAL_EN (g != 3)
    ) u_dut (
      .clk_cpu   (clk),
      .reset     (rst[g]),
      .opcode    (op[g]),
      .func      (fn[g]),
      .zero      (zero),
      .IorD      (iord[g]),
      .MemRead   (mrd[g]),
      .MemWrite  (mwr[g]),
      .IRWrite   (irw[g]),
      .RegWrite  (rgw[g]),
      .RegDst    (rdst[g]),
      .Mem2Reg   (m2r[g]),
      .ALUSrcA   (srca[g]),
      .ALUSrcB   (srcb[g]),
      .ExtOp     (ext[g]),
      .ALUControl(aluc[g]),
      .PCWrite   (pcw[g]),
      .BranchEq  (beq[g]),
      .BranchNeq (bne[g]),
      .PCSrc     (pcs[g]),
      .illegal   (ill[g]),
      .state     (st[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset instance g for one edge, then release; returns in the first IF cycle.
  task automatic start(input int g);
    rst[g] = 1'b1;
    tick();
    rst[g] = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      op[i]  = 6'h00;
      fn[i]  = 6'h00;
    end
    zero  = 1'b0;
    op[0] = 6'h23;
    tick();
    tick();

    // Reset: IF state but all strobes and selects forced low.
    chk("rst_state", st[0], 0);
    chk("rst_memread", mrd[0], 0);
    chk("rst_irwrite", irw[0], 0);
    chk("rst_pcwrite", pcw[0], 0);
    chk("rst_alusrcb", srcb[0], 0);
    chk("rst_aluctl", aluc[0], 0);

    // add, L=0: 0,1,6,7,0.
    op[0] = 6'h00;
    fn[0] = 6'h20;
    start(0);
    chk("add_if_state", st[0], 0);
    chk("add_if_memread", mrd[0], 1);
    chk("add_if_irwrite", irw[0], 1);
    chk("add_if_pcwrite", pcw[0], 1);
    chk("add_if_alusrcb", srcb[0], 1);
    tick();
    chk("add_id_state", st[0], 1);
    chk("add_id_alusrcb", srcb[0], 3);
    chk("add_id_illegal", ill[0], 0);
    tick();
    chk("add_ex_state", st[0], 6);
    chk("add_ex_aluctl", aluc[0], 3'b010);
    chk("add_ex_srca", srca[0], 1);
    tick();
    chk("add_wb_state", st[0], 7);
    chk("add_wb_regwrite", rgw[0], 1);
    chk("add_wb_regdst", rdst[0], 1);
    chk("add_wb_mem2reg", m2r[0], 0);
    tick();
    chk("add_done_state", st[0], 0);

    // lw, L=2: 3 IF + ID + MADR + 3 MRD + MWB = 9 cycles.
    op[1] = 6'h23;
    start(1);
    chk("lw_if1_state", st[1], 0);
    chk("lw_if1_irwrite", irw[1], 0);
    chk("lw_if1_memread", mrd[1], 1);
    tick();
    chk("lw_if2_state", st[1], 0);
    chk("lw_if2_irwrite", irw[1], 0);
    tick();
    chk("lw_if3_irwrite", irw[1], 1);
    tick();
    chk("lw_id_state", st[1], 1);
    tick();
    chk("lw_madr_state", st[1], 2);
    chk("lw_madr_srcb", srcb[1], 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("lw_mrd_state", st[1], 3);
      chk("lw_mrd_memread", mrd[1], 1);
      chk("lw_mrd_iord", iord[1], 1);
    end
    tick();
    chk("lw_mwb_state", st[1], 4);
    chk("lw_mwb_regwrite", rgw[1], 1);
    chk("lw_mwb_mem2reg", m2r[1], 1);
    tick();
    chk("lw_done_state", st[1], 0);

    // beq with zero=1, bne with zero=0.
    op[0] = 6'h04;
    zero  = 1'b1;
    start(0);
    tick();
    chk("beq_id_state", st[0], 1);
    tick();
    chk("beq_br_state", st[0], 8);
    chk("beq_br_beq", beq[0], 1);
    chk("beq_br_bne", bne[0], 0);
    chk("beq_br_pcsrc", pcs[0], 1);
    chk("beq_br_aluctl", aluc[0], 3'b110);
    tick();
    chk("beq_done_state", st[0], 0);
    op[0] = 6'h05;
    zero  = 1'b0;
    start(0);
    tick();
    tick();
    chk("bne_br_state", st[0], 8);
    chk("bne_br_beq", beq[0], 0);
    chk("bne_br_bne", bne[0], 1);
    chk("bne_br_pcsrc", pcs[0], 1);
    tick();
    chk("bne_done_state", st[0], 0);

    // ori: zero-extended immediate, OR.
    op[0] = 6'h0D;
    start(0);
    tick();
    tick();
    chk("ori_exi_state", st[0], 10);
    chk("ori_exi_extop", ext[0], 0);
    chk("ori_exi_aluctl", aluc[0], 3'b001);
    chk("ori_exi_srcb", srcb[0], 2);
    tick();
    chk("ori_wbi_state", st[0], 11);
    chk("ori_wbi_regwrite", rgw[0], 1);
    chk("ori_wbi_regdst", rdst[0], 0);

    // jal enabled.
    op[0] = 6'h03;
    start(0);
    tick();
    chk("jal_id_illegal", ill[0], 0);
    tick();
    chk("jal_state", st[0], 12);
    chk("jal_pcwrite", pcw[0], 1);
    chk("jal_regwrite", rgw[0], 1);
    chk("jal_regdst", rdst[0], 2);
    chk("jal_mem2reg", m2r[0], 2);
    chk("jal_pcsrc", pcs[0], 2);
    tick();
    chk("jal_done_state", st[0], 0);

    // jal disabled: illegal pulse in ID, back to IF.
    op[3] = 6'h03;
    start(3);
    tick();
    chk("jal0_id_state", st[3], 1);
    chk("jal0_id_illegal", ill[3], 1);
    chk("jal0_id_regwrite", rgw[3], 0);
    chk("jal0_id_pcwrite", pcw[3], 0);
    tick();
    chk("jal0_next_state", st[3], 0);
    chk("jal0_next_illegal", ill[3], 0);

    // Unknown opcode and unknown R-type func.
    op[0] = 6'h3F;
    start(0);
    tick();
    chk("badop_illegal", ill[0], 1);
    chk("badop_regwrite", rgw[0], 0);
    chk("badop_memwrite", mwr[0], 0);
    chk("badop_pcwrite", pcw[0], 0);
    tick();
    chk("badop_next_state", st[0], 0);
    chk("badop_next_illegal", ill[0], 0);
    op[0] = 6'h00;
    fn[0] = 6'h3F;
    start(0);
    tick();
    chk("badfn_illegal", ill[0], 1);
    chk("badfn_regwrite", rgw[0], 0);
    tick();
    chk("badfn_next_state", st[0], 0);

    // sw, L=3, reset raised on the second MWR cycle.
    op[2] = 6'h2B;
    start(2);
    tick();
    tick();
    tick();
    tick();
    chk("sw_id_state", st[2], 1);
    tick();
    chk("sw_madr_state", st[2], 2);
    tick();
    chk("sw_mwr1_state", st[2], 5);
    chk("sw_mwr1_memwrite", mwr[2], 1);
    chk("sw_mwr1_iord", iord[2], 1);
    tick();
    rst[2] = 1'b1;
    #1;
    chk("sw_rst_memwrite", mwr[2], 0);
    chk("sw_rst_iord", iord[2], 0);
    tick();
    rst[2] = 1'b0;
    #1;
    chk("sw_refetch_state", st[2], 0);
    chk("sw_refetch_memread", mrd[2], 1);
    chk("sw_refetch1_irwrite", irw[2], 0);
    tick();
    chk("sw_refetch2_irwrite", irw[2], 0);
    tick();
    chk("sw_refetch3_irwrite", irw[2], 0);
    tick();
    chk("sw_refetch4_irwrite", irw[2], 1);
    tick();
    chk("sw_refetch_id_state", st[2], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Multi-cycle MIPS control unit: a Moore FSM that sequences the fetch/decode/execute/memory/writeback steps of one instruction over 3–5+ cycles on a shared memory port and single ALU. It is the successor to the single-cycle control decoder and drives the multi-cycle datapath. It is generalised with a parametrised memory wait-state count and an optional jal path.

Parameters:
MEM_LAT, 0, extra wait cycles per memory access (0..15); IF and memory-access states each last MEM_LAT+1 cycles
JAL_EN, 1, 1 = decode jal (opcode 0x03); 0 = jal treated as illegal

Ports:
clk_cpu  input  1  CPU clock, all state changes on rising edge
reset  input  1  synchronous, active-high
opcode  input  6  IR[31:26], valid from ID onward
func  input  6  IR[5:0]
zero  input  1  ALU zero flag, sampled in BR state
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  load IR and MDR
RegWrite  output  1  register file write enable
RegDst  output  2  write register select: 0 = rt, 1 = rd, 2 = $31
Mem2Reg  output  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC
ALUSrcA  output  1  0 = PC, 1 = A(rs)
ALUSrcB  output  2  0 = B(rt), 1 = const 4, 2 = ext imm, 3 = sext imm<<2
ExtOp  output  1  1 = sign-extend imm, 0 = zero-extend
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor, 011 lui (imm<<16)
PCWrite  output  1  unconditional PC load
BranchEq  output  1  PC load if zero
BranchNeq  output  1  PC load if !zero
PCSrc  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target {PC[31:28], IR[25:0], 2'b00}
illegal  output  1  one-cycle pulse on unsupported opcode/func
state  output  4  current state, for the debug display

Behaviour:
- States: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, EXR=6, WBR=7, BR=8, JMP=9, EXI=10, WBI=11, JAL=12.
- Synchronous reset: state<=IF, wait counter<=0. While reset is high, every strobe (MemRead, MemWrite, IRWrite, RegWrite, PCWrite, BranchEq, BranchNeq, illegal) is forced to 0 combinationally. All mux selects are 0 during reset.
- Outputs are a pure function of state (plus the counter and opcode/func as noted). There is no output register.
- IF: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUControl=add, PCSrc=0.
  - The 4-bit counter increments each cycle. IRWrite and PCWrite assert only when counter==MEM_LAT; on that cycle counter<=0 and the FSM goes to ID.
- ID: ALUSrcA=0, ALUSrcB=3, ExtOp=1, add (branch target into ALUOut). Next state by opcode:
  - 0x00 R-type -> EXR (func add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, nor 0x27; other func -> illegal)
  - lw 0x23 / sw 0x2B -> MADR
  - beq 0x04 / bne 0x05 -> BR
  - j 0x02 -> JMP
  - jal 0x03 (JAL_EN=1) -> JAL
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F -> EXI
  - else: illegal=1 for this cycle, next IF, no write strobes.
- MADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, add. Goes to MRD for lw, MWR for sw.
- MRD / MWR: IorD=1, MemRead or MemWrite held for MEM_LAT+1 cycles using the counter. Exits on counter==MEM_LAT: MRD->MWB, MWR->IF.
- MWB: RegDst=0, Mem2Reg=1, RegWrite=1 -> IF.
- EXR: ALUSrcA=1, ALUSrcB=0, ALUControl from func -> WBR.
- WBR: RegDst=1, Mem2Reg=0, RegWrite=1 -> IF.
- EXI: ALUSrcA=1, ALUSrcB=2. ExtOp=1 for addi/slti, 0 for andi/ori/lui. ALUControl: add/slt/and/or/lui -> WBI.
- WBI: RegDst=0, Mem2Reg=0, RegWrite=1 -> IF.
- BR: ALUSrcA=1, ALUSrcB=0, sub, PCSrc=1. BranchEq=1 for beq, BranchNeq=1 for bne (the datapath gates with zero) -> IF.
- JMP: PCWrite=1, PCSrc=2 -> IF.
- JAL: PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, Mem2Reg=2. PC here is already PC+4, so it is written to $31 -> IF.
- Latency with L=MEM_LAT: beq/bne/j/jal = 3+L, R-type/I-ALU/sw = 4+L (sw 4+2L), lw = 5+2L cycles.
- Reset mid-instruction aborts immediately. No strobe fires on the reset cycle, and fetch restarts with counter=0.
- opcode/func may change outside ID/EX/WB states without effect.

Test Plan:
- MEM_LAT=0, add (op 0, func 0x20): state sequence 0,1,6,7,0. In state 7: RegWrite=1, RegDst=1, Mem2Reg=0. In state 6: ALUControl=010.
- MEM_LAT=2, lw (op 0x23): IF lasts 3 cycles with IRWrite only on the 3rd. MRD lasts 3 cycles with MemRead and IorD high. Total 9 cycles; RegWrite with Mem2Reg=1 in MWB.
- beq (op 0x04) with zero=1, then bne (op 0x05) with zero=0: BR state shows BranchEq=1 / BranchNeq=1 respectively, PCSrc=1, ALUControl=110. 3 cycles each.
- jal (op 0x03), JAL_EN=1: JAL state asserts PCWrite, RegWrite, RegDst=2, Mem2Reg=2, PCSrc=2. With JAL_EN=0, same opcode gives an illegal pulse in ID and returns to IF with no write.
- Op 0x3F, and R-type func 0x3F: illegal=1 for exactly one cycle in ID, next state 0, RegWrite/MemWrite/PCWrite never asserted.
- MEM_LAT=3, sw with reset raised on the 2nd MWR cycle: MemWrite=0 in the reset cycle, state=0 and counter=0 next cycle, new fetch takes 4 cycles.
